// File: rtl/sha256_pkg.sv
// Shared SHA-256 padding definitions: block geometry, padder FSM states
// and the block-count helper N = ceil((L+65)/512).
package sha256_pkg;

  localparam int BLOCK_W     = 512;
  localparam int LEN_FIELD_W = 64;

  typedef logic [511:0] block_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    EMIT = 2'd2
  } pad_state_t;

  // L bits + the '1' bit + the length field, rounded up to whole blocks.
  function automatic int num_blocks(input int l);
    return (l + LEN_FIELD_W + 1 + BLOCK_W - 1) / BLOCK_W;
  endfunction

endpackage

// File: rtl/sha256_block_count.sv
// Combinational block count for a padded message of len bits.
// Ports: len (message length in bits) -> n (number of 512-bit blocks).
module sha256_block_count
  import sha256_pkg::*;
#(
  parameter int LEN_W = 10
) (
  input  logic [LEN_W-1:0] len,
  output logic [1:0]       n
);

  always_comb begin
    n = 2'(num_blocks(int'(len)));
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: accepts a raw message of up to MAX_BITS bits and
// streams the padded image as 512-bit blocks over a valid/ready handshake.
// Ports: clk, rst (sync, active high); msg_valid/msg_ready/msg_data/msg_len
// in; blk_valid/blk_ready/blk_data/blk_idx/blk_first/blk_last out; len_err.
// Build option PAD_LEN_CHECK_EN: reject msg_len > MAX_BITS with a len_err
// pulse; without it the length is saturated to MAX_BITS and len_err is 0.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int MAX_BITS = 1023,
  parameter int LEN_W    = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                msg_valid,
  output logic                msg_ready,
  input  logic [MAX_BITS-1:0] msg_data,
  input  logic [LEN_W-1:0]    msg_len,
  output logic                blk_valid,
  input  logic                blk_ready,
  output logic [511:0]        blk_data,
  output logic [1:0]          blk_idx,
  output logic                blk_first,
  output logic                blk_last,
  output logic                len_err
);

  localparam int MAX_BLOCKS = (MAX_BITS + 65 + 511) / 512;
  localparam int PW         = MAX_BLOCKS * BLOCK_W;

  pad_state_t          state_q, state_d;
  logic                ready_q, ready_d;
  logic [MAX_BITS-1:0] msg_q, msg_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [1:0]          n_q, n_d;
  logic [1:0]          idx_q, idx_d;
  logic [PW-1:0]       pad_q, pad_d;
  block_t              data_q, data_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;

  logic [1:0]          n_calc;
  logic [PW-1:0]       img;
  logic [LEN_W-1:0]    len_in;
  logic                len_bad;
  logic [MAX_BITS-1:0] mask;

  sha256_block_count #(
    .LEN_W (LEN_W)
  ) u_count (
    .len (len_q),
    .n   (n_calc)
  );

  always_comb begin
`ifdef PAD_LEN_CHECK_EN
    len_bad = int'(msg_len) > MAX_BITS;
    len_in  = msg_len;
`else
    len_bad = 1'b0;
    len_in  = (int'(msg_len) > MAX_BITS) ?
              LEN_W'(MAX_BITS) : msg_len;
`endif
    // Keep only the first len_in message bits (MSB side).
    mask = {MAX_BITS{1'b1}} << (MAX_BITS - int'(len_in));
  end

  // Padded image kept MSB-aligned in pad: message, '1', zeros,
  // and the length field in the low 64 bits of the N-block image.
  always_comb begin
    img = '0;
    img[PW-1 -: MAX_BITS] = msg_q;
    img = img | (PW'(1'b1) << (PW - 1 - int'(len_q)));
    img = img | (PW'(len_q) << (PW - int'(n_calc) * BLOCK_W));
  end

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    msg_d   = msg_q;
    len_d   = len_q;
    n_d     = n_q;
    idx_d   = idx_q;
    pad_d   = pad_q;
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (msg_valid && ready_q) begin
          if (len_bad) begin
            err_d = 1'b1;
          end else begin
            msg_d   = msg_data & mask;
            len_d   = len_in;
            ready_d = 1'b0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        n_d     = n_calc;
        pad_d   = img;
        idx_d   = 2'd0;
        state_d = EMIT;
      end
      EMIT: begin
        if (!valid_q) begin
          data_d  = pad_q[PW-1 -: BLOCK_W];
          pad_d   = pad_q << BLOCK_W;
          valid_d = 1'b1;
        end else if (blk_ready) begin
          if (idx_q == n_q - 2'd1) begin
            valid_d = 1'b0;
            ready_d = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d  = idx_q + 2'd1;
            data_d = pad_q[PW-1 -: BLOCK_W];
            pad_d  = pad_q << BLOCK_W;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      msg_q   <= '0;
      len_q   <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      pad_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      msg_q   <= msg_d;
      len_q   <= len_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      pad_q   <= pad_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign msg_ready = ready_q;
  assign blk_valid = valid_q;
  assign blk_data  = data_q;
  assign blk_idx   = idx_q;
  assign blk_first = valid_q && (idx_q == 2'd0);
  assign blk_last  = valid_q && (idx_q == n_q - 2'd1);
  assign len_err   = err_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Testbench for sha256_msg_padder: table vectors, hand-written corner
// sequences and random messages against a bit-queue padding model.
module tb_sha256_msg_padder;

  typedef logic [511:0] blk_t;

  typedef struct {
    bit sel;
    int len;
    int stall;
    int exp_n;
    bit exp_err;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          msg_valid;
  logic [1022:0] msg_data;
  logic [9:0]    msg_len;
  logic          blk_ready;
  bit            sel;

  logic       a_msg_ready, a_blk_valid, a_blk_first, a_blk_last, a_len_err;
  logic [511:0] a_blk_data;
  logic [1:0] a_blk_idx;
  logic       b_msg_ready, b_blk_valid, b_blk_first, b_blk_last, b_len_err;
  logic [511:0] b_blk_data;
  logic [1:0] b_blk_idx;

  int checks = 0;
  int failures = 0;
  blk_t exp_q[$];
  blk_t got_q[$];

  always #5 clk = ~clk;

  sha256_msg_padder #(.MAX_BITS(1023), .LEN_W(10)) u_dut (
    .clk(clk), .rst(rst),
    .msg_valid(msg_valid && !sel), .msg_ready(a_msg_ready),
    .msg_data(msg_data), .msg_len(msg_len),
    .blk_valid(a_blk_valid), .blk_ready(blk_ready),
    .blk_data(a_blk_data), .blk_idx(a_blk_idx),
    .blk_first(a_blk_first), .blk_last(a_blk_last),
    .len_err(a_len_err)
  );

  sha256_msg_padder #(.MAX_BITS(640), .LEN_W(10)) u_dut640 (
    .clk(clk), .rst(rst),
    .msg_valid(msg_valid && sel), .msg_ready(b_msg_ready),
    .msg_data(msg_data[1022 -: 640]), .msg_len(msg_len),
    .blk_valid(b_blk_valid), .blk_ready(blk_ready),
    .blk_data(b_blk_data), .blk_idx(b_blk_idx),
    .blk_first(b_blk_first), .blk_last(b_blk_last),
    .len_err(b_len_err)
  );

  wire        c_ready = sel ? b_msg_ready : a_msg_ready;
  wire        c_valid = sel ? b_blk_valid : a_blk_valid;
  wire [511:0] c_data = sel ? b_blk_data : a_blk_data;
  wire [1:0]  c_idx   = sel ? b_blk_idx : a_blk_idx;
  wire        c_first = sel ? b_blk_first : a_blk_first;
  wire        c_last  = sel ? b_blk_last : a_blk_last;
  wire        c_err   = sel ? b_len_err : a_len_err;

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [1022:0] rnd_vec();
    logic [1023:0] t;
    for (int i = 0; i < 32; i++) t[i*32 +: 32] = $urandom;
    return t[1022:0];
  endfunction

  // Reference: pad as a plain bit sequence, then cut into 512-bit blocks.
  task automatic model(input bit s, input logic [1022:0] d,
                       input int len, output bit err);
    bit   bits[$];
    int   mb;
    int   l;
    blk_t b;
    mb = s ? 640 : 1023;
    l = len;
    err = 1'b0;
    exp_q.delete();
    if (l > mb) begin
`ifdef PAD_LEN_CHECK_EN
      err = 1'b1;
      return;
`else
      l = mb;
`endif
    end
    for (int i = 0; i < l; i++) bits.push_back(d[1022-i]);
    bits.push_back(1'b1);
    while (bits.size() % 512 != 448) bits.push_back(1'b0);
    for (int i = 63; i >= 0; i--) bits.push_back(i < 32 ? l[i] : 1'b0);
    for (int k = 0; k < bits.size() / 512; k++) begin
      for (int j = 0; j < 512; j++) b[511-j] = bits[k*512+j];
      exp_q.push_back(b);
    end
  endtask

  task automatic run_msg(input bit s, input logic [1022:0] d,
                         input int len, input int stall,
                         input int exp_n, input bit exp_err);
    bit merr;
    int n_exp;
    bit e_exp;
    int cnt;
    int lat;
    int k;
    model(s, d, len, merr);
    n_exp = (exp_n < 0) ? exp_q.size() : exp_n;
    e_exp = (exp_n < 0) ? merr : exp_err;
    sel = s;
    cnt = 0;
    while (!c_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("accept_ready", 512'(c_ready), 512'(1));
    if (!c_ready) return;
    msg_valid = 1'b1;
    msg_data = d;
    msg_len = len[9:0];
    @(negedge clk);
    msg_valid = 1'b0;
    msg_data = rnd_vec();
    msg_len = 10'($urandom);
    if (e_exp) begin
      chk("len_err_pulse", 512'(c_err), 512'(1));
      @(negedge clk);
      chk("len_err_drop", 512'(c_err), 512'(0));
      repeat (4) begin
        @(negedge clk);
        chk("err_no_blk", 512'(c_valid), 512'(0));
      end
      chk("err_ready", 512'(c_ready), 512'(1));
      return;
    end
    chk("len_err_idle", 512'(c_err), 512'(0));
    lat = 0;
    while (!c_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 512'(lat), 512'(2));
    got_q.delete();
    k = 0;
    cnt = 0;
    while (c_valid && cnt < 200) begin
      chk("blk_data", c_data, (k < exp_q.size()) ? exp_q[k] : '0);
      chk("blk_idx", 512'(c_idx), 512'(k[1:0]));
      chk("blk_first", 512'(c_first), 512'(k == 0));
      chk("blk_last", 512'(c_last), 512'(k == n_exp - 1));
      blk_ready = (stall == 0) || ($urandom_range(99) >= stall);
      if (blk_ready) begin
        got_q.push_back(c_data);
        k++;
      end
      @(negedge clk);
      cnt++;
    end
    blk_ready = 1'b0;
    chk("blk_count", 512'(k), 512'(n_exp));
    chk("ready_after_last", 512'(c_ready), 512'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    logic [1022:0] d;
    blk_t snap;
    bit e;
    int cnt;

    rst = 1'b1;
    msg_valid = 1'b0;
    msg_data = '0;
    msg_len = '0;
    blk_ready = 1'b0;
    sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 512'(a_msg_ready), 512'(0));
    chk("rst_valid", 512'(a_blk_valid), 512'(0));
    chk("rst_data", a_blk_data, '0);
    chk("rst_idx", 512'(a_blk_idx), 512'(0));
    chk("rst_first", 512'(a_blk_first), 512'(0));
    chk("rst_last", 512'(a_blk_last), 512'(0));
    chk("rst_err", 512'(a_len_err), 512'(0));
    chk("rst_ready640", 512'(b_msg_ready), 512'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 512'(a_msg_ready), 512'(1));
    chk("ready_after_rst640", 512'(b_msg_ready), 512'(1));

    vecs.push_back('{0, 0, 0, 1, 0});
    vecs.push_back('{0, 1, 30, 1, 0});
    vecs.push_back('{0, 447, 0, 1, 0});
    vecs.push_back('{0, 448, 40, 2, 0});
    vecs.push_back('{0, 959, 0, 2, 0});
    vecs.push_back('{0, 960, 50, 3, 0});
    vecs.push_back('{0, 1023, 0, 3, 0});
    vecs.push_back('{1, 640, 0, 2, 0});
    vecs.push_back('{1, 447, 20, 1, 0});
`ifdef PAD_LEN_CHECK_EN
    vecs.push_back('{1, 1023, 0, 0, 1});
    vecs.push_back('{1, 641, 0, 0, 1});
`else
    vecs.push_back('{1, 1023, 0, 2, 0});
    vecs.push_back('{1, 641, 30, 2, 0});
`endif
    foreach (vecs[i])
      run_msg(vecs[i].sel, rnd_vec(), vecs[i].len, vecs[i].stall,
              vecs[i].exp_n, vecs[i].exp_err);

    // "abc"
    d = rnd_vec();
    d[1022 -: 24] = 24'h616263;
    run_msg(0, d, 24, 0, 1, 0);
    chk("abc_w0", 512'(got_q[0][511 -: 32]), 512'(32'h61626380));
    chk("abc_mid", 512'(got_q[0][479:32]), '0);
    chk("abc_w15", 512'(got_q[0][31:0]), 512'(32'h18));

    // L=448: '1' bit spills into block 0, length alone in block 1
    run_msg(0, rnd_vec(), 448, 0, 2, 0);
    chk("l448_b0_tail", 512'(got_q[0][63:0]),
        512'(64'h8000_0000_0000_0000));
    chk("l448_b1_hi", 512'(got_q[1][511:32]), '0);
    chk("l448_b1_len", 512'(got_q[1][31:0]), 512'(32'h1C0));

    // 80-byte header
    d = rnd_vec();
    run_msg(0, d, 640, 0, 2, 0);
    chk("hdr_tail", 512'(got_q[1][511 -: 128]), 512'(d[510 -: 128]));
    chk("hdr_w4", 512'(got_q[1][383 -: 32]), 512'(32'h80000000));
    chk("hdr_zero", 512'(got_q[1][351:32]), '0);
    chk("hdr_len", 512'(got_q[1][31:0]), 512'(32'h280));

    // Backpressure: 5 stalled cycles, then one block per cycle
    d = rnd_vec();
    model(0, d, 640, e);
    sel = 1'b0;
    msg_valid = 1'b1;
    msg_data = d;
    msg_len = 10'd640;
    @(negedge clk);
    msg_valid = 1'b0;
    cnt = 0;
    while (!a_blk_valid && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    snap = a_blk_data;
    chk("bp_first", snap, exp_q[0]);
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_data", a_blk_data, snap);
      chk("bp_hold_idx", 512'(a_blk_idx), 512'(0));
      chk("bp_hold_valid", 512'(a_blk_valid), 512'(1));
    end
    blk_ready = 1'b1;
    @(negedge clk);
    chk("bp_next_idx", 512'(a_blk_idx), 512'(1));
    chk("bp_next_data", a_blk_data, exp_q[1]);
    chk("bp_next_last", 512'(a_blk_last), 512'(1));
    @(negedge clk);
    blk_ready = 1'b0;
    chk("bp_done_valid", 512'(a_blk_valid), 512'(0));
    chk("bp_done_ready", 512'(a_msg_ready), 512'(1));

    // Reset after block 0 of a 2-block message
    msg_valid = 1'b1;
    msg_data = rnd_vec();
    msg_len = 10'd448;
    @(negedge clk);
    msg_valid = 1'b0;
    cnt = 0;
    while (!a_blk_valid && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    chk("rst_mid_b1", 512'(a_blk_idx), 512'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", 512'(a_blk_valid), 512'(0));
    chk("rst_mid_ready", 512'(a_msg_ready), 512'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_recover", 512'(a_msg_ready), 512'(1));
    run_msg(0, rnd_vec(), 0, 0, 1, 0);
    chk("l0_block", got_q[0], {32'h80000000, 480'd0});

    // Random messages on both instances
    for (int i = 0; i < 24; i++)
      run_msg(1'($urandom), rnd_vec(), int'($urandom_range(1023)),
              int'($urandom_range(60)), -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
